// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified I/D memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_STARVE = 3;
    localparam int unsigned BE_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive fetch denials; sat_o forces the next fetch grant.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MaxStarve = MAX_STARVE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CntW = cnt_width(MaxStarve);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxStarve);

    logic [CntW-1:0] cnt_q;

    // Clear wins over increment; the count holds once it reaches CntMax.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign sat_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the LSU,
// LSU-first with a starvation guard for fetch, and steers each response to its issuer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrW     = 13,
    parameter int unsigned MaxStarve = MAX_STARVE
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             if_req_i,
    input  logic [AddrW-1:0] if_addr_i,
    input  logic             if_flush_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [Width-1:0] if_rdata_o,

    input  logic             ls_req_i,
    input  logic             ls_we_i,
    input  logic [BE_W-1:0]  ls_be_i,
    input  logic [AddrW-1:0] ls_addr_i,
    input  logic [Width-1:0] ls_wdata_i,
    output logic             ls_gnt_o,
    output logic             ls_rvalid_o,
    output logic [Width-1:0] ls_rdata_o,

    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [BE_W-1:0]  mem_be_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    input  logic [Width-1:0] mem_rdata_i,

    output logic             stall_if_o
);

    owner_e owner_q;
    owner_e owner_d;
    logic   store_q;
    logic   flush_q;
    logic   starve_sat;

    arb_starve_cnt #(
        .MaxStarve (MaxStarve)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (if_req_i & ~if_gnt_o),
        .clr_i  (if_gnt_o | ~if_req_i),
        .sat_o  (starve_sat)
    );

    // Fetch wins only when the LSU is idle or fetch has been starved long enough.
    assign if_gnt_o   = rst_ni & if_req_i & (~ls_req_i | starve_sat);
    assign ls_gnt_o   = rst_ni & ls_req_i & ~if_gnt_o;
    assign stall_if_o = if_req_i & ~if_gnt_o;

    // The granted requester drives the memory port in its grant cycle.
    always_comb begin
        mem_req_o   = if_gnt_o | ls_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
        end else if (ls_gnt_o) begin
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_be_i;
            mem_wdata_o = ls_wdata_i;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_o) begin
            owner_d = OWN_IF;
        end else if (ls_gnt_o) begin
            owner_d = OWN_LS;
        end
    end

    // A flush hits the outstanding fetch response if there is one, otherwise the
    // fetch being granted alongside it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= ls_gnt_o & ls_we_i;
            flush_q <= if_gnt_o & if_flush_i & (owner_q != OWN_IF);
        end
    end

    // Response mux: only the owner sees memory data; a reset in the response cycle drops it.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        if (rst_ni) begin
            case (owner_q)
                OWN_IF: begin
                    if (!flush_q && !if_flush_i) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end
                end
                OWN_LS: begin
                    ls_rvalid_o = 1'b1;
                    if (!store_q) begin
                        ls_rdata_o = mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX_ST = 3;
    localparam int WORDS  = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, ls_req, ls_we;
    logic [12:0] if_addr, ls_addr;
    logic [3:0]  ls_be;
    logic [31:0] ls_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, stall_if;
    logic [3:0]  mem_be;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Memory seen by the DUT, and the model's own copy of what it must contain.
    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    // Model state: consecutive fetch denials and the one outstanding transaction.
    int          starve    = 0;
    int          pend_own  = 0;
    bit          pend_st   = 1'b0;
    bit          pend_fl   = 1'b0;
    logic [31:0] pend_data = '0;

    mem_port_arbiter #(.Width(32), .AddrW(13), .MaxStarve(MAX_ST)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .ls_req_i    (ls_req),
        .ls_we_i     (ls_we),
        .ls_be_i     (ls_be),
        .ls_addr_i   (ls_addr),
        .ls_wdata_i  (ls_wdata),
        .ls_gnt_o    (ls_gnt),
        .ls_rvalid_o (ls_rvalid),
        .ls_rdata_o  (ls_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .stall_if_o  (stall_if)
    );

    always #5 clk = ~clk;

    // Single-port memory with 1-cycle read latency; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr[12:2]];
        else                    mem_rdata <= $urandom;
        if (mem_req && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Check this cycle's outputs against the model, then advance the model.
    task automatic model_cycle();
        logic        e_ig, e_lg, e_ir, e_lr, new_fl;
        logic [31:0] e_id, e_ld;
        e_ig = rst_n && if_req && (!ls_req || starve >= MAX_ST);
        e_lg = rst_n && ls_req && !e_ig;
        e_ir = 1'b0; e_lr = 1'b0; e_id = '0; e_ld = '0;
        if (rst_n && pend_own == 1 && !pend_fl && !if_flush) begin
            e_ir = 1'b1; e_id = pend_data;
        end
        if (rst_n && pend_own == 2) begin
            e_lr = 1'b1; e_ld = pend_st ? 32'h0 : pend_data;
        end
        chk("if_gnt",    32'(if_gnt),    32'(e_ig));
        chk("ls_gnt",    32'(ls_gnt),    32'(e_lg));
        chk("stall_if",  32'(stall_if),  32'(if_req && !e_ig));
        chk("mem_req",   32'(mem_req),   32'(e_ig || e_lg));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ir));
        chk("if_rdata",  if_rdata,       e_id);
        chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lr));
        chk("ls_rdata",  ls_rdata,       e_ld);
        if (e_ig) begin
            chk("mem_addr_if",  32'(mem_addr),  32'(if_addr));
            chk("mem_we_if",    32'(mem_we),    32'h0);
            chk("mem_be_if",    32'(mem_be),    32'hF);
            chk("mem_wdata_if", mem_wdata,      32'h0);
        end
        if (e_lg) begin
            chk("mem_addr_ls",  32'(mem_addr),  32'(ls_addr));
            chk("mem_we_ls",    32'(mem_we),    32'(ls_we));
            chk("mem_be_ls",    32'(mem_be),    32'(ls_be));
            chk("mem_wdata_ls", mem_wdata,      ls_wdata);
        end
        if (!rst_n) begin
            starve = 0; pend_own = 0; pend_st = 1'b0; pend_fl = 1'b0;
        end else begin
            new_fl = e_ig && if_flush && (pend_own != 1);
            if (if_req && !e_ig) starve = (starve < MAX_ST) ? starve + 1 : MAX_ST;
            else                 starve = 0;
            pend_st = 1'b0;
            if (e_ig) begin
                pend_own  = 1;
                pend_data = ref_mem[if_addr[12:2]];
            end else if (e_lg) begin
                pend_own  = 2;
                pend_st   = ls_we;
                pend_data = ref_mem[ls_addr[12:2]];
                if (ls_we)
                    for (int b = 0; b < 4; b++)
                        if (ls_be[b]) ref_mem[ls_addr[12:2]][8*b +: 8] = ls_wdata[8*b +: 8];
            end else begin
                pend_own = 0;
            end
            pend_fl = new_fl;
        end
    endtask

    // Apply one cycle of inputs just after the edge; return at the falling edge.
    task automatic drive(input logic r, input logic ir, input logic [12:0] ia, input logic fl,
                         input logic lr, input logic lw, input logic [3:0] lbe,
                         input logic [12:0] la, input logic [31:0] lwd);
        @(posedge clk);
        #1;
        rst_n = r; if_req = ir; if_addr = ia; if_flush = fl;
        ls_req = lr; ls_we = lw; ls_be = lbe; ls_addr = la; ls_wdata = lwd;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    endtask

    task automatic fetch(input logic [12:0] a, input logic fl);
        drive(1'b1, 1'b1, a, fl, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    endtask

    task automatic lsop(input logic we, input logic [3:0] be, input logic [12:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 13'h0, 1'b0, 1'b1, we, be, a, d);
    endtask

    task automatic both(input logic r, input logic [12:0] ia, input logic [12:0] la);
        drive(r, 1'b1, ia, 1'b0, 1'b1, 1'b0, 4'hF, la, 32'h0);
    endtask

    task automatic preset(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        preset(0, 32'h1111_0001);
        preset(1, 32'h2222_0002);
        preset(2, 32'h3333_0003);
        preset(64, 32'h0000_0000);

        // Reset: grants suppressed, stall follows the fetch request.
        drive(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
        both(1'b0, 13'h0, 13'h0);
        chk("rst_stall", 32'(stall_if), 32'h1);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        idle();
        chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);

        // Fetch-only stream.
        fetch(13'h000, 1'b0);
        chk("if_only_gnt", 32'(if_gnt), 32'h1);
        chk("if_only_stall", 32'(stall_if), 32'h0);
        fetch(13'h004, 1'b0);
        chk("if_only_r0", if_rdata, 32'h1111_0001);
        fetch(13'h008, 1'b0);
        chk("if_only_r1", if_rdata, 32'h2222_0002);
        idle();
        chk("if_only_r2", if_rdata, 32'h3333_0003);
        chk("if_only_v2", 32'(if_rvalid), 32'h1);

        // Partial store then load-back.
        lsop(1'b1, 4'b0011, 13'h100, 32'hDEAD_BEEF);
        chk("st_gnt", 32'(ls_gnt), 32'h1);
        lsop(1'b0, 4'hF, 13'h100, 32'h0);
        chk("st_ack_v", 32'(ls_rvalid), 32'h1);
        chk("st_ack_d", ls_rdata, 32'h0);
        idle();
        chk("ld_data", ls_rdata, 32'h0000_BEEF);

        // Sustained contention: LS,LS,LS,IF repeating.
        for (int k = 0; k < 8; k++) begin
            both(1'b1, 13'(4 * k), 13'h200);
            chk("dual_ls_gnt", 32'(ls_gnt), (k % 4 == 3) ? 32'h0 : 32'h1);
            chk("dual_if_gnt", 32'(if_gnt), (k % 4 == 3) ? 32'h1 : 32'h0);
        end
        idle();

        // Flush of an outstanding fetch; the fetch granted with the flush survives.
        fetch(13'h000, 1'b0);
        fetch(13'h004, 1'b1);
        chk("flush_v", 32'(if_rvalid), 32'h0);
        chk("flush_d", if_rdata, 32'h0);
        idle();
        chk("post_flush_v", 32'(if_rvalid), 32'h1);
        chk("post_flush_d", if_rdata, 32'h2222_0002);
        fetch(13'h008, 1'b1);
        idle();
        chk("flush_at_gnt", 32'(if_rvalid), 32'h0);

        // Reset in a load's response cycle; starvation count must restart.
        both(1'b1, 13'h0, 13'h100);
        both(1'b1, 13'h0, 13'h100);
        both(1'b0, 13'h0, 13'h100);
        chk("rst_drop", 32'(ls_rvalid), 32'h0);
        both(1'b1, 13'h0, 13'h100);
        chk("rst_rel_rv", 32'(ls_rvalid), 32'h0);
        chk("rst_rel_ls", 32'(ls_gnt), 32'h1);
        both(1'b1, 13'h0, 13'h100);
        chk("rst_cnt1", 32'(ls_gnt), 32'h1);
        both(1'b1, 13'h0, 13'h100);
        chk("rst_cnt2", 32'(ls_gnt), 32'h1);
        both(1'b1, 13'h0, 13'h100);
        chk("rst_cnt3", 32'(if_gnt), 32'h1);
        idle();

        // Alternating owners: data reaches only the issuer.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) lsop(1'b0, 4'hF, 13'h100, 32'h0);
            else            fetch(13'h000, 1'b0);
            if (k % 2 == 1) begin
                chk("alt_ls_d", ls_rdata, 32'h0000_BEEF);
                chk("alt_if_0", if_rdata, 32'h0);
            end else if (k > 0) begin
                chk("alt_if_d", if_rdata, 32'h1111_0001);
                chk("alt_ls_0", ls_rdata, 32'h0);
            end
        end

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            drive(1'($urandom_range(0, 63) != 0),
                  1'($urandom_range(0, 3) != 0),
                  13'($urandom_range(0, 511)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) == 0),
                  4'($urandom),
                  13'($urandom_range(0, 511)),
                  32'($urandom));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
